// File: rtl/sc_fifo_ext.sv
// sc_fifo_ext - single-clock first-word-fall-through FIFO.
//
// Purpose:
//   Buffers a stream between a producer and a consumer in the same clock
//   domain. Storage is a RAM of WORDS_AMOUNT-1 entries plus a show-ahead
//   output register that always holds the head word, so the total capacity
//   is WORDS_AMOUNT words and any depth >= 2 is allowed. Offers programmable
//   almost-full / almost-empty thresholds, a synchronous flush and sticky
//   overflow / underflow error flags.
//
// Ports:
//   clk_i          - clock, all logic on its rising edge
//   rst_n_i        - synchronous active-low reset (same effect as flush)
//   flush_i        - synchronous clear of contents and error flags
//   wr_i           - write request, accepted when not full
//   wr_data_i      - write data
//   rd_i           - pop request for the word on rd_data_o, accepted when not empty
//   rd_data_o      - head word, valid while empty_o is 0
//   used_words_o   - words accepted and not yet popped
//   full_o         - used_words_o == WORDS_AMOUNT
//   empty_o        - no valid word in the output register
//   almost_full_o  - used_words_o >= AF_THRESH
//   almost_empty_o - used_words_o <= AE_THRESH
//   overflow_o     - sticky: a write was attempted while full
//   underflow_o    - sticky: a read was attempted while empty
module sc_fifo_ext #(
  parameter int DATA_WIDTH   = 8,
  parameter int WORDS_AMOUNT = 8,
  parameter int AF_THRESH    = WORDS_AMOUNT - 1,
  parameter int AE_THRESH    = 1,
  parameter int CNT_WIDTH    = $clog2(WORDS_AMOUNT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [CNT_WIDTH-1:0]  used_words_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  // Two writes can land in the RAM before the first one reaches an empty
  // output register, so the RAM never gets fewer than two entries.
  localparam int RAM_DEPTH = (WORDS_AMOUNT - 1 < 2) ? 2 : WORDS_AMOUNT - 1;
  localparam int PTR_WIDTH = $clog2(RAM_DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(RAM_DEPTH - 1);
  localparam logic AF_RST = (AF_THRESH <= 0);
  localparam logic AE_RST = (AE_THRESH >= 0);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] head_q;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d, ram_cnt_q, ram_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  fill_pend_q, fill_pend_d;
  logic                  full_q, almost_full_q, almost_empty_q;
  logic                  overflow_q, underflow_q;
  logic                  clear, wr_req, rd_req, ram_rd;

  assign clear = ~rst_n_i | flush_i;

  always_comb begin
    wr_req      = wr_i & ~full_q & ~clear;
    rd_req      = rd_i & out_valid_q & ~clear;
    // An empty output register is refilled only after it has seen the RAM
    // non-empty for a full cycle (fill_pend_q); a pop refills immediately.
    ram_rd      = (rd_req | (~out_valid_q & fill_pend_q)) & (ram_cnt_q != '0) & ~clear;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (wr_req) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
    end
    if (ram_rd) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
    end
    ram_cnt_d   = ram_cnt_q + CNT_WIDTH'(wr_req) - CNT_WIDTH'(ram_rd);
    count_d     = count_q + CNT_WIDTH'(wr_req) - CNT_WIDTH'(rd_req);
    out_valid_d = out_valid_q;
    if (ram_rd) begin
      out_valid_d = 1'b1;
    end else if (rd_req) begin
      out_valid_d = 1'b0;
    end
    fill_pend_d = ~out_valid_q & (ram_cnt_q != '0);
  end

  // Control state; status flags are registered from the next-state count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ram_cnt_q      <= '0;
      out_valid_q    <= 1'b0;
      fill_pend_q    <= 1'b0;
      full_q         <= 1'b0;
      almost_full_q  <= AF_RST;
      almost_empty_q <= AE_RST;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ram_cnt_q      <= ram_cnt_d;
      out_valid_q    <= out_valid_d;
      fill_pend_q    <= fill_pend_d;
      full_q         <= (count_d == CNT_WIDTH'(WORDS_AMOUNT));
      almost_full_q  <= (32'(count_d) >= AF_THRESH);
      almost_empty_q <= (32'(count_d) <= AE_THRESH);
      overflow_q     <= overflow_q | (wr_i & full_q);
      underflow_q    <= underflow_q | (rd_i & ~out_valid_q);
    end
  end

  // Data path has no reset; contents are don't-care while not valid.
  // The head register reads the old RAM word when a write hits the same slot.
  always_ff @(posedge clk_i) begin
    if (wr_req) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
    if (ram_rd) begin
      head_q <= mem[rd_ptr_q];
    end
  end

  assign rd_data_o      = head_q;
  assign used_words_o   = count_q;
  assign full_o         = full_q;
  assign empty_o        = ~out_valid_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sc_fifo_ext.sv
// tb_sc_fifo_ext - self-checking bench for sc_fifo_ext (WORDS_AMOUNT = 6).
//
// A queue-based model tracks accepted words with the edge they were written
// on; a word becomes visible on an empty output two edges after its write,
// or right at a pop if it was written at least one edge earlier. Every edge
// the compare process checks all DUT outputs against the model, and the
// directed sequence adds hand-computed literal expectations.
module tb_sc_fifo_ext;

  localparam int DW = 8;
  localparam int W  = 6;
  localparam int CW = $clog2(W + 1);
  localparam int AF = W - 1;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] used;
  logic          full, empty, af, ae, ovf, unf;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_data[$];
  int            m_edge[$];
  bit            m_vis = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  int            edge_no = 0;

  always #5 clk = ~clk;

  sc_fifo_ext #(
    .DATA_WIDTH  (DW),
    .WORDS_AMOUNT(W),
    .AF_THRESH   (AF),
    .AE_THRESH   (AE),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .flush_i       (flush),
    .wr_i          (wr),
    .wr_data_i     (wr_data),
    .rd_i          (rd),
    .rd_data_o     (rd_data),
    .used_words_o  (used),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (af),
    .almost_empty_o(ae),
    .overflow_o    (ovf),
    .underflow_o   (unf)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the
  // rising edge that samples them.
  task automatic applyStimulus(input logic rn, input logic fl, input logic w,
                               input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    rst_n   = rn;
    flush   = fl;
    wr      = w;
    wr_data = d;
    rd      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_used"}, 32'(used), 32'd0);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_af"}, 32'(af), 32'd0);
    checkOutput({tag, "_ae"}, 32'(ae), 32'd1);
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
    checkOutput({tag, "_unf"}, 32'(unf), 32'd0);
  endtask

  // Model update on each rising edge, then compare all outputs against it.
  always @(posedge clk) begin : model_proc
    bit wr_ok;
    bit rd_ok;
    int cnt;
    cnt = m_data.size();
    if (!rst_n || flush) begin
      m_data.delete();
      m_edge.delete();
      m_vis = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wr_ok = wr && (cnt < W);
      rd_ok = rd && m_vis;
      if (wr && cnt == W) m_ovf = 1'b1;
      if (rd && !m_vis) m_unf = 1'b1;
      if (rd_ok) begin
        void'(m_data.pop_front());
        void'(m_edge.pop_front());
        m_vis = (m_data.size() > 0) && (m_edge[0] <= edge_no - 1);
      end else if (!m_vis) begin
        m_vis = (m_data.size() > 0) && (m_edge[0] <= edge_no - 2);
      end
      if (wr_ok) begin
        m_data.push_back(wr_data);
        m_edge.push_back(edge_no);
      end
    end
    edge_no++;
    #2;
    cnt = m_data.size();
    checkOutput("m_used", 32'(used), 32'(cnt));
    checkOutput("m_full", 32'(full), 32'(cnt == W));
    checkOutput("m_empty", 32'(empty), 32'(!m_vis));
    checkOutput("m_af", 32'(af), 32'(cnt >= AF));
    checkOutput("m_ae", 32'(ae), 32'(cnt <= AE));
    checkOutput("m_ovf", 32'(ovf), 32'(m_ovf));
    checkOutput("m_unf", 32'(unf), 32'(m_unf));
    if (m_vis) checkOutput("m_data", 32'(rd_data), 32'(m_data[0]));
  end

  initial begin
    // Reset
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkResetState("reset");

    // Single word into empty FIFO: visible after the second following edge
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    checkOutput("a5_used_e0", 32'(used), 32'd1);
    checkOutput("a5_empty_e0", 32'(empty), 32'd1);
    idle();
    checkOutput("a5_empty_e1", 32'(empty), 32'd1);
    idle();
    checkOutput("a5_empty_e2", 32'(empty), 32'd0);
    checkOutput("a5_data_e2", 32'(rd_data), 32'hA5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("a5_pop_empty", 32'(empty), 32'd1);
    checkOutput("a5_pop_used", 32'(used), 32'd0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 3) checkOutput("fill_af_at4", 32'(af), 32'd0);
      if (i == 4) begin
        checkOutput("fill_af_at5", 32'(af), 32'd1);
        checkOutput("fill_full_at5", 32'(full), 32'd0);
      end
    end
    checkOutput("fill_full_at6", 32'(full), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h06, 1'b0);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    checkOutput("ovf_used", 32'(used), 32'd6);
    for (int i = 0; i < W; i++) begin
      checkOutput("drain_data", 32'(rd_data), 32'(i));
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_unf", 32'(unf), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("flush_ovf", 32'(ovf), 32'd0);

    // Sustained simultaneous traffic from half full, across pointer wraps
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
    idle();
    idle();
    for (int k = 0; k < 40; k++) begin
      checkOutput("stream_data", 32'(rd_data), 32'(k));
      applyStimulus(1'b1, 1'b0, 1'b1, 8'(k + 3), 1'b1);
    end
    checkOutput("stream_used", 32'(used), 32'd3);
    checkOutput("stream_head", 32'(rd_data), 32'd40);

    // Full with read and write together
    for (int i = 43; i < 46; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
    checkOutput("both_full_pre", 32'(full), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
    checkOutput("both_full_used", 32'(used), 32'd5);
    checkOutput("both_full_ovf", 32'(ovf), 32'd1);
    checkOutput("both_full_head", 32'(rd_data), 32'd41);

    // Empty with read and write together
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
    checkOutput("both_empty_used", 32'(used), 32'd1);
    checkOutput("both_empty_unf", 32'(unf), 32'd1);
    idle();
    idle();
    checkOutput("both_empty_data", 32'(rd_data), 32'h77);

    // Mid-stream flush with a write in the same cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    checkOutput("flush_pre_used", 32'(used), 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    checkResetState("flush");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
    checkOutput("3c_empty_e0", 32'(empty), 32'd1);
    idle();
    idle();
    checkOutput("3c_empty_e2", 32'(empty), 32'd0);
    checkOutput("3c_data", 32'(rd_data), 32'h3C);

    // Reset in the middle of random traffic
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    checkResetState("midreset");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hD1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hD2, 1'b0);
    idle();
    checkOutput("after_reset_first", 32'(rd_data), 32'hD1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("after_reset_second", 32'(rd_data), 32'hD2);

    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
